// File: rtl/sprite_ram_arbiter_if.sv
// Bus bundle between the sprite address generators, the frame RAM and the
// arbiter. The master side is the requester/RAM environment; the slave side
// is the arbiter.
//   req       per-requester read request, held until granted
//   req_addr  flattened request addresses, slice i = [i*ADDR_W +: ADDR_W]
//   gnt       one-hot combinational grant
//   ram_addr  frame RAM read address (0 when idle)
//   ram_data  frame RAM read data, RD_LATENCY cycles after the address
//   rd_valid  one-hot registered return pulse
//   rd_data   per-requester held palette index
//   busy      a read is in flight
interface sprite_ram_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned DATA_W  = 4
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [ADDR_W-1:0]         ram_addr;
  logic [DATA_W-1:0]         ram_data;
  logic [NUM_REQ-1:0]        rd_valid;
  logic [NUM_REQ*DATA_W-1:0] rd_data;
  logic                      busy;

  modport master (
    output req, req_addr, ram_data,
    input  gnt, ram_addr, rd_valid, rd_data, busy
  );

  modport slave (
    input  req, req_addr, ram_data,
    output gnt, ram_addr, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/sprite_ram_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite frame RAM read port
// among NUM_REQ sprite renderers. Grants one requester per cycle, drives the
// RAM address, tracks in-flight reads through an RD_LATENCY-deep id pipeline
// and returns each palette index to the requester that issued it.
//   Clk    system clock, rising edge
//   Reset  asynchronous active-low reset
//   bus    sprite_ram_arbiter_if slave modport (req/req_addr/ram_data in;
//          gnt/ram_addr/rd_valid/rd_data/busy out)
module sprite_ram_arbiter #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned DATA_W     = 4,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  sprite_ram_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned LAST  = RD_LATENCY - 1;

  logic [IDX_W-1:0]          rr_ptr;
  logic [NUM_REQ-1:0]        gnt_c;
  logic [IDX_W-1:0]          gnt_idx_c;
  logic                      gnt_any_c;
  logic [ADDR_W-1:0]         ram_addr_c;
  logic                      pipe_vld [RD_LATENCY];
  logic [IDX_W-1:0]          pipe_id  [RD_LATENCY];
  logic [NUM_REQ-1:0]        rd_valid_q;
  logic [NUM_REQ-1:0]        rd_valid_nxt_c;
  logic [NUM_REQ*DATA_W-1:0] rd_data_q;
  logic                      busy_q;
  logic                      busy_nxt_c;
  int unsigned               cand_c;

  // Round-robin search starting at rr_ptr; grant is forced off during reset.
  always_comb begin
    gnt_c      = '0;
    gnt_idx_c  = '0;
    gnt_any_c  = 1'b0;
    ram_addr_c = '0;
    cand_c     = 0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand_c = 32'(rr_ptr) + i;
      if (cand_c >= NUM_REQ) begin
        cand_c = cand_c - NUM_REQ;
      end
      if (!gnt_any_c && bus.req[IDX_W'(cand_c)]) begin
        gnt_any_c = 1'b1;
        gnt_idx_c = IDX_W'(cand_c);
      end
    end
    if (!Reset) begin
      gnt_any_c = 1'b0;
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_any_c && (gnt_idx_c == IDX_W'(i))) begin
        gnt_c[i]   = 1'b1;
        ram_addr_c = bus.req_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  // Next-cycle capture pulse and busy flag, derived from the pipeline tail.
  always_comb begin
    rd_valid_nxt_c = '0;
    busy_nxt_c     = gnt_any_c;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pipe_vld[LAST] && (pipe_id[LAST] == IDX_W'(i))) begin
        rd_valid_nxt_c[i] = 1'b1;
      end
    end
    for (int unsigned s = 0; s < RD_LATENCY; s++) begin
      busy_nxt_c = busy_nxt_c | pipe_vld[s];
    end
  end

  // Pointer moves just past the granted index; holds when idle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rr_ptr <= '0;
    end else if (gnt_any_c) begin
      rr_ptr <= (gnt_idx_c == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx_c + 1'b1;
    end
  end

  // In-flight read tracking: stage 0 takes this cycle's grant, later stages shift.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      for (int unsigned s = 0; s < RD_LATENCY; s++) begin
        pipe_vld[s] <= 1'b0;
        pipe_id[s]  <= '0;
      end
    end else begin
      pipe_vld[0] <= gnt_any_c;
      pipe_id[0]  <= gnt_idx_c;
      for (int unsigned s = 1; s < RD_LATENCY; s++) begin
        pipe_vld[s] <= pipe_vld[s-1];
        pipe_id[s]  <= pipe_id[s-1];
      end
    end
  end

  // Capture register: RAM data lands in the owning requester's slice.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      rd_valid_q <= rd_valid_nxt_c;
      busy_q     <= busy_nxt_c;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (rd_valid_nxt_c[i]) begin
          rd_data_q[i*DATA_W +: DATA_W] <= bus.ram_data;
        end
      end
    end
  end

  assign bus.gnt      = gnt_c;
  assign bus.ram_addr = ram_addr_c;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_data_q;
  assign bus.busy     = busy_q;

endmodule

// File: doc/sprite_ram_arbiter.md
Name: sprite_ram_arbiter

Overview:
- Shares one synchronous sprite frame RAM (19-bit read address, 4-bit palette index out) among several sprite renderers, e.g. player, enemy, item and ending overlays.
- Each cycle it grants the RAM read port to one requester using round-robin order.
- It drives the RAM address, tracks in-flight reads through a latency pipeline, and returns each palette index to the requester that issued it.
- Each requester keeps its own held copy of the last returned data.
- Sits between the per-sprite address generators and the single frame RAM instance in the colour-mapper path.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 19, RAM read address width.
- DATA_W, 4, palette index width.
- RD_LATENCY, 1, RAM read latency in clock cycles (1..3).

Ports:
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset (Reset==0 clears all state immediately).
- req  in  NUM_REQ  per-requester read request; held high until its gnt bit is seen.
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]; stable while req[i] is high.
- gnt  out  NUM_REQ  one-hot combinational grant for the current cycle.
- ram_addr  out  ADDR_W  address to the frame RAM; equals the granted requester's req_addr, 0 when no grant.
- ram_data  in  DATA_W  RAM output, valid RD_LATENCY cycles after its address.
- rd_valid  out  NUM_REQ  one-hot registered pulse; bit i = data for requester i is present this cycle.
- rd_data  out  NUM_REQ*DATA_W  per-requester held data; slice i updates only when rd_valid[i] pulses.
- busy  out  1  high while any read is in flight in the latency pipeline.

Behaviour:
- Reset values (Reset==0):
  - rr_ptr=0 and all rd_valid=0.
  - All rd_data slices=0, busy=0, and the pipeline is emptied.
  - gnt=0 and ram_addr=0 are forced while Reset is low.
- Arbitration (combinational):
  - Search req starting at index rr_ptr, wrapping NUM_REQ-1 -> 0.
  - The first set bit wins; gnt has at most one bit set.
- Pointer update on the rising edge:
  - If grant to index k, rr_ptr <= (k+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
- Pipeline:
  - RD_LATENCY stages, each holding {valid, id}.
  - Stage 0 loads {|gnt, index(gnt)} each cycle; later stages shift.
  - Final stage drives the capture.
- Capture and response timing:
  - When the final stage is valid with id j: rd_data slice j <= ram_data, and rd_valid[j] is set for exactly one cycle.
  - rd_valid[j] rises RD_LATENCY+1 edges after the gnt cycle, aligned with the registered rd_data update (RAM latency plus one capture register).
- Throughput:
  - One grant per cycle; back-to-back grants are allowed, no bubbles.
  - With all requesters asserting continuously, each is granted once every NUM_REQ cycles.
- Handshake:
  - A request is consumed on the edge where its gnt bit was high.
  - A requester wanting another read keeps req high with a new address the next cycle.
- Fairness bound: a held request is granted within NUM_REQ cycles.
- Simultaneous events:
  - A capture for requester j and a new grant to j in the same cycle are independent.
  - Capture writes the old read's data; the new read returns later.
- busy = OR of all pipeline valid bits plus the capture-stage valid.
- Reset mid-operation:
  - In-flight reads are discarded; no rd_valid pulse follows after Reset releases.
  - Arbitration restarts at index 0.
- Widths: index(gnt) is $clog2(NUM_REQ) bits; no arithmetic beyond the pointer's modular increment.

Test Plan:
- Reset check: Reset=0 with req=4'b1111 -> gnt=0, ram_addr=0, rd_valid=0, rd_data all 0, busy=0.
- Single requester with RD_LATENCY=1:
  - Stimulus: req=4'b0100, addr2=19'd2000, RAM model returns addr[3:0].
  - Response: gnt=4'b0100 in cycle 0; rd_valid=4'b0100 after 2 edges; rd_data slice2=4'h0.
- Full contention with rr_ptr=0:
  - Stimulus: req=4'b1111 held 8 cycles.
  - Response: gnt sequence 0001, 0010, 0100, 1000, 0001, 0010, 0100, 1000; each requester granted exactly 2 times.
- Wrap and skip:
  - Stimulus: rr_ptr=3 (after grant to 2), req=4'b0011.
  - Response: gnt=0001, then 0010, then 0001.
- Latency sweep:
  - Stimulus: RD_LATENCY=3, back-to-back grants to 1 then 3.
  - Response: rd_valid=0010 on edge 4 and 1000 on edge 5, each with correct data; busy high from the first grant until the last capture.
- Reset mid-flight:
  - Stimulus: grant to 0, then Reset=0 for 1 cycle before the data returns.
  - Response: no rd_valid pulse, rd_data slice0=0, next grant begins search at index 0.
